gpr_file: RTL and testbench
===========================

GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL provide parameter REG_NUM, default 32: number of general-purpose registers.
REQ-002 SHALL provide parameter DATA_W, default 32: register data width (REG_DATA_BUS).
REQ-003 SHALL provide port CLK  input  1: single clock; all state updates on posedge CLK.
REQ-004 SHALL provide port RST  input  1: reset, synchronous, active-high (RST_EN = 1).
REQ-005 SHALL provide port WB_GPR_WE  input  1: write enable from the write-back stage.
REQ-006 SHALL provide port WB_GPR_WADDR  input  5: write register index.
REQ-007 SHALL provide port WB_GPR_WDATA  input  32: write data.
REQ-008 SHALL provide port ID_RS_RE  input  1: read enable, port RS.
REQ-009 SHALL provide port ID_RS_RADDR  input  5: read index, port RS.
REQ-010 SHALL provide port ID_RS_RDATA  output  32: read data, port RS.
REQ-011 SHALL provide port ID_RT_RE  input  1: read enable, port RT.
REQ-012 SHALL provide port ID_RT_RADDR  input  5: read index, port RT.
REQ-013 SHALL provide port ID_RT_RDATA  output  32: read data, port RT.
REQ-014 SHALL provide port WB_HILO_WE  input  1: HI/LO write enable from the write-back stage.
REQ-015 SHALL provide port WB_HI_WDATA  input  32: HI write data.
REQ-016 SHALL provide port WB_LO_WDATA  input  32: LO write data.
REQ-017 SHALL provide port HI_RDATA  output  32: current HI value, with bypass.
REQ-018 SHALL provide port LO_RDATA  output  32: current LO value, with bypass.

Function
REQ-019 SHALL write WB_GPR_WDATA into register WB_GPR_WADDR at posedge CLK when WB_GPR_WE=1, RST=0 and WB_GPR_WADDR!=0.
REQ-020 SHALL keep register 0 at 0x00000000 at all times, so writes to index 0 are discarded.
REQ-021 SHALL make RS/RT reads combinational, with zero-cycle latency from address to data.
REQ-022 SHALL drive a read port to 0x00000000 when RST=1, when its RE=0, or when its RADDR=0; this order of priority is fixed.
REQ-023 SHALL otherwise bypass a read port to WB_GPR_WDATA when WB_GPR_WE=1 and WB_GPR_WADDR equals its RADDR (write-first).
REQ-024 SHALL otherwise drive a read port with the stored register value.
REQ-025 SHALL let RS and RT read the same index simultaneously, both returning identical data, including the bypassed case.
REQ-026 SHALL write both HI and LO at posedge CLK when WB_HILO_WE=1 and RST=0; partial HI/LO writes do not exist.
REQ-027 SHALL drive HI_RDATA/LO_RDATA to WB_HI_WDATA/WB_LO_WDATA when WB_HILO_WE=1, otherwise to the stored HI/LO; both read 0 while RST=1.
REQ-028 SHALL hold all state unchanged when no write enable is active; the block has no stall input and relies on upstream stage registers to present WE=0 during bubbles.
REQ-029 SHALL keep the GPR and HI/LO write paths independent, so both may write in the same cycle.

Reset
REQ-030 SHALL clear all REG_NUM registers, HI and LO to 0x00000000 at the first posedge CLK with RST=1.
REQ-031 SHALL give RST priority over any simultaneous write enable, so a write in a reset cycle is lost.
REQ-032 SHALL hold every output at 0x00000000 while RST=1, independent of inputs.

Structure
REQ-033 SHALL take REG_ADDR_BUS, REG_DATA_BUS, REG_NUM, ZERO_WORD, REG_ZERO_ADDR, RST_EN and WE from the shared defines package.
REQ-034 SHALL implement HI/LO storage and bypass as sub-module hilo_reg, instantiated once inside gpr_file.
REQ-035 SHALL implement the register array as flip-flops, not inferred RAM, so that reset clears every entry.

Verification
REQ-036 SHALL verify reset: write 0xDEADBEEF to r5, then assert RST for 1 cycle; a read of r5 then returns 0x00000000, and HI/LO read 0.
REQ-037 SHALL verify the zero register: WE=1, WADDR=0, WDATA=0xFFFFFFFF; RS read of r0 returns 0x00000000 in the same cycle and after the next cycle.
REQ-038 SHALL verify bypass: with r7=0x11111111, WE=1, WADDR=7, WDATA=0x22222222 and RS=RT=7 in the same cycle, both ports return 0x22222222 before the edge and still 0x22222222 after it.
REQ-039 SHALL verify read enable: with r3=0x12345678 and RS_RE=0, RS_RADDR=3, RS returns 0; with RT_RE=1, RT_RADDR=3, RT returns 0x12345678.
REQ-040 SHALL verify HI/LO: WB_HILO_WE=1, HI=0xAAAA0000, LO=0x0000BBBB with a concurrent GPR write of 0x5 to r31; HI/LO are bypassed in that cycle and all three values hold after the edge.
REQ-041 SHALL verify reset priority: RST=1 together with WE=1, WADDR=9, WDATA=0x9; after RST deasserts, r9 reads 0x00000000.

Source files
------------

// File: rtl/gpr_file_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpr_file_pkg                                           |
// | Description : Shared register-file widths and encodings.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package gpr_file_pkg;
  localparam int                       REG_ADDR_BUS  = 5;
  localparam int                       REG_DATA_BUS  = 32;
  localparam int                       REG_NUM       = 32;
  localparam logic [REG_DATA_BUS-1:0]  ZERO_WORD     = '0;
  localparam logic [REG_ADDR_BUS-1:0]  REG_ZERO_ADDR = '0;
  localparam logic                     RST_EN        = 1'b1;
  localparam logic                     WE            = 1'b1;
endpackage
`default_nettype wire

// File: rtl/gpr_file_hilo_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hilo_reg                                               |
// | Description : HI/LO multiply-divide result pair with write bypass.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hilo_reg
  import gpr_file_pkg::*;
#(
  parameter int DATA_W = REG_DATA_BUS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HILO_WE,
  input  logic [DATA_W-1:0] HI_WDATA,
  input  logic [DATA_W-1:0] LO_WDATA,
  output logic [DATA_W-1:0] HI_RDATA,
  output logic [DATA_W-1:0] LO_RDATA
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // HI and LO always update together; reset wins over a concurrent write.
  always_ff @(posedge CLK) begin
    if (RST == RST_EN) begin
      r_hi <= DATA_W'(ZERO_WORD);
      r_lo <= DATA_W'(ZERO_WORD);
    end else if (HILO_WE == WE) begin
      r_hi <= HI_WDATA;
      r_lo <= LO_WDATA;
    end
  end

  // Readout forwards the in-flight write so consumers see it this cycle.
  always_comb begin
    HI_RDATA = r_hi;
    LO_RDATA = r_lo;
    if (RST == RST_EN) begin
      HI_RDATA = DATA_W'(ZERO_WORD);
      LO_RDATA = DATA_W'(ZERO_WORD);
    end else if (HILO_WE == WE) begin
      HI_RDATA = HI_WDATA;
      LO_RDATA = LO_WDATA;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpr_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpr_file                                               |
// | Description : 2-read / 1-write general-purpose register file with    |
// |               write-first bypass, hard-wired r0 and HI/LO pair.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module gpr_file
  import gpr_file_pkg::*;
#(
  parameter int REG_NUM = gpr_file_pkg::REG_NUM,
  parameter int DATA_W  = gpr_file_pkg::REG_DATA_BUS
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WB_GPR_WE,
  input  logic [REG_ADDR_BUS-1:0] WB_GPR_WADDR,
  input  logic [DATA_W-1:0]       WB_GPR_WDATA,
  input  logic                    ID_RS_RE,
  input  logic [REG_ADDR_BUS-1:0] ID_RS_RADDR,
  output logic [DATA_W-1:0]       ID_RS_RDATA,
  input  logic                    ID_RT_RE,
  input  logic [REG_ADDR_BUS-1:0] ID_RT_RADDR,
  output logic [DATA_W-1:0]       ID_RT_RDATA,
  input  logic                    WB_HILO_WE,
  input  logic [DATA_W-1:0]       WB_HI_WDATA,
  input  logic [DATA_W-1:0]       WB_LO_WDATA,
  output logic [DATA_W-1:0]       HI_RDATA,
  output logic [DATA_W-1:0]       LO_RDATA
);

  // Flip-flop array so that reset can clear every entry in one cycle.
  logic [DATA_W-1:0] r_regs [REG_NUM];

  logic w_rst;
  logic w_gpr_wr;

  assign w_rst    = (RST == RST_EN);
  assign w_gpr_wr = (WB_GPR_WE == WE);

  // Register writes; r0 is never written so it stays at its reset value.
  always_ff @(posedge CLK) begin
    if (w_rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= DATA_W'(ZERO_WORD);
      end
    end else if (w_gpr_wr && (WB_GPR_WADDR != REG_ZERO_ADDR)) begin
      r_regs[WB_GPR_WADDR] <= WB_GPR_WDATA;
    end
  end

  // RS read: reset, disabled port and r0 force zero, then write-first bypass.
  always_comb begin
    ID_RS_RDATA = r_regs[ID_RS_RADDR];
    if (w_rst || (ID_RS_RE != WE) || (ID_RS_RADDR == REG_ZERO_ADDR)) begin
      ID_RS_RDATA = DATA_W'(ZERO_WORD);
    end else if (w_gpr_wr && (WB_GPR_WADDR == ID_RS_RADDR)) begin
      ID_RS_RDATA = WB_GPR_WDATA;
    end
  end

  // RT read: same priority as RS.
  always_comb begin
    ID_RT_RDATA = r_regs[ID_RT_RADDR];
    if (w_rst || (ID_RT_RE != WE) || (ID_RT_RADDR == REG_ZERO_ADDR)) begin
      ID_RT_RDATA = DATA_W'(ZERO_WORD);
    end else if (w_gpr_wr && (WB_GPR_WADDR == ID_RT_RADDR)) begin
      ID_RT_RDATA = WB_GPR_WDATA;
    end
  end

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo_reg (
    .CLK      (CLK),
    .RST      (RST),
    .HILO_WE  (WB_HILO_WE),
    .HI_WDATA (WB_HI_WDATA),
    .LO_WDATA (WB_LO_WDATA),
    .HI_RDATA (HI_RDATA),
    .LO_RDATA (LO_RDATA)
  );

endmodule
`default_nettype wire

// File: tb/tb_gpr_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_gpr_file                                            |
// | Description : Scoreboard bench for gpr_file.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_gpr_file;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WB_GPR_WE;
  logic [4:0]  WB_GPR_WADDR;
  logic [31:0] WB_GPR_WDATA;
  logic        ID_RS_RE;
  logic [4:0]  ID_RS_RADDR;
  logic [31:0] ID_RS_RDATA;
  logic        ID_RT_RE;
  logic [4:0]  ID_RT_RADDR;
  logic [31:0] ID_RT_RDATA;
  logic        WB_HILO_WE;
  logic [31:0] WB_HI_WDATA;
  logic [31:0] WB_LO_WDATA;
  logic [31:0] HI_RDATA;
  logic [31:0] LO_RDATA;

  gpr_file u_dut (
    .CLK          (CLK),
    .RST          (RST),
    .WB_GPR_WE    (WB_GPR_WE),
    .WB_GPR_WADDR (WB_GPR_WADDR),
    .WB_GPR_WDATA (WB_GPR_WDATA),
    .ID_RS_RE     (ID_RS_RE),
    .ID_RS_RADDR  (ID_RS_RADDR),
    .ID_RS_RDATA  (ID_RS_RDATA),
    .ID_RT_RE     (ID_RT_RE),
    .ID_RT_RADDR  (ID_RT_RADDR),
    .ID_RT_RDATA  (ID_RT_RDATA),
    .WB_HILO_WE   (WB_HILO_WE),
    .WB_HI_WDATA  (WB_HI_WDATA),
    .WB_LO_WDATA  (WB_LO_WDATA),
    .HI_RDATA     (HI_RDATA),
    .LO_RDATA     (LO_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef enum logic [1:0] {P_RS, P_RT, P_HI, P_LO} port_e;
  typedef struct {
    port_e       port;
    logic [31:0] exp;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    total = 0;
  int    bad   = 0;

  // Reference state for the random phase
  logic [31:0] mdl_regs [32];
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input port_e p, input logic [31:0] e);
    exp_t x;
    x.port = p;
    x.exp  = e;
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  // Let inputs settle, then compare every queued expectation with the DUT.
  task automatic drain();
    exp_t        x;
    string       t;
    logic [31:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      case (x.port)
        P_RS:    obs = ID_RS_RDATA;
        P_RT:    obs = ID_RT_RDATA;
        P_HI:    obs = HI_RDATA;
        default: obs = LO_RDATA;
      endcase
      check(t, obs, x.exp);
    end
  endtask

  // Wait for the falling edge and apply one cycle of stimulus.
  task automatic step(input logic rst,
                      input logic gwe, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rse, input logic [4:0] rsa,
                      input logic rte, input logic [4:0] rta,
                      input logic hwe, input logic [31:0] hi, input logic [31:0] lo);
    @(negedge CLK);
    RST = rst;
    WB_GPR_WE = gwe; WB_GPR_WADDR = wa; WB_GPR_WDATA = wd;
    ID_RS_RE = rse;  ID_RS_RADDR = rsa;
    ID_RT_RE = rte;  ID_RT_RADDR = rta;
    WB_HILO_WE = hwe; WB_HI_WDATA = hi; WB_LO_WDATA = lo;
  endtask

  function automatic logic [31:0] mdl_read(input logic re, input logic [4:0] a,
                                           input logic gwe, input logic [4:0] wa,
                                           input logic [31:0] wd);
    if (!re || a == 5'd0) return 32'h0;
    if (gwe && wa == a)   return wd;
    return mdl_regs[a];
  endfunction

  initial begin
    logic        gwe, rse, rte, hwe;
    logic [4:0]  wa, rsa, rta;
    logic [31:0] wd, hi, lo;

    // Outputs forced to zero during reset whatever the inputs do
    step(1, 1, 5, 32'hDEADBEEF, 1, 5, 1, 5, 1, 32'h1, 32'h2);
    push("rst_hold_rs", P_RS, 32'h0); push("rst_hold_rt", P_RT, 32'h0);
    push("rst_hold_hi", P_HI, 32'h0); push("rst_hold_lo", P_LO, 32'h0);
    drain();

    // Post-reset state; the write during reset was dropped
    step(0, 0, 0, 0, 1, 5, 1, 5, 0, 0, 0);
    push("init_r5_rs", P_RS, 32'h0); push("init_hi", P_HI, 32'h0);
    push("init_lo", P_LO, 32'h0);
    drain();

    // Reset clears a written register and HI/LO
    step(0, 1, 5, 32'hDEADBEEF, 1, 5, 0, 0, 1, 32'hCAFE0001, 32'hCAFE0002);
    push("wr_r5_byp", P_RS, 32'hDEADBEEF); push("wr_hi_byp", P_HI, 32'hCAFE0001);
    drain();
    step(0, 0, 0, 0, 1, 5, 1, 5, 0, 0, 0);
    push("r5_rs", P_RS, 32'hDEADBEEF); push("r5_rt", P_RT, 32'hDEADBEEF);
    push("hi_held", P_HI, 32'hCAFE0001); push("lo_held", P_LO, 32'hCAFE0002);
    drain();
    step(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    push("rst_r5", P_RS, 32'h0);
    drain();
    step(0, 0, 0, 0, 1, 5, 1, 5, 0, 0, 0);
    push("after_rst_r5", P_RS, 32'h0); push("after_rst_hi", P_HI, 32'h0);
    push("after_rst_lo", P_LO, 32'h0);
    drain();

    // Zero register ignores writes and is never bypassed
    step(0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 0);
    push("r0_same_rs", P_RS, 32'h0); push("r0_same_rt", P_RT, 32'h0);
    drain();
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    push("r0_next", P_RS, 32'h0);
    drain();

    // Write-first bypass on both ports
    step(0, 1, 7, 32'h11111111, 0, 0, 0, 0, 0, 0, 0);
    drain();
    step(0, 1, 7, 32'h22222222, 1, 7, 1, 7, 0, 0, 0);
    push("byp_rs", P_RS, 32'h22222222); push("byp_rt", P_RT, 32'h22222222);
    drain();
    step(0, 0, 0, 0, 1, 7, 1, 7, 0, 0, 0);
    push("r7_rs", P_RS, 32'h22222222); push("r7_rt", P_RT, 32'h22222222);
    drain();

    // Read enable gates each port independently
    step(0, 1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    drain();
    step(0, 0, 0, 0, 0, 3, 1, 3, 0, 0, 0);
    push("re0_rs", P_RS, 32'h0); push("re1_rt", P_RT, 32'h12345678);
    drain();

    // HI/LO and GPR write in the same cycle
    step(0, 1, 31, 32'h5, 1, 31, 0, 0, 1, 32'hAAAA0000, 32'h0000BBBB);
    push("r31_byp", P_RS, 32'h5); push("hi_byp", P_HI, 32'hAAAA0000);
    push("lo_byp", P_LO, 32'h0000BBBB);
    drain();
    step(0, 0, 0, 0, 1, 31, 1, 3, 0, 0, 0);
    push("r31_held", P_RS, 32'h5); push("r3_held", P_RT, 32'h12345678);
    push("hi_held2", P_HI, 32'hAAAA0000); push("lo_held2", P_LO, 32'h0000BBBB);
    drain();

    // Reset has priority over a concurrent write
    step(1, 1, 9, 32'h9, 1, 9, 1, 9, 1, 32'h7, 32'h8);
    push("rstpri_rs", P_RS, 32'h0); push("rstpri_hi", P_HI, 32'h0);
    drain();
    step(0, 0, 0, 0, 1, 9, 1, 31, 0, 0, 0);
    push("r9_lost", P_RS, 32'h0); push("r31_cleared", P_RT, 32'h0);
    push("hi_cleared", P_HI, 32'h0);
    drain();

    // Random traffic against a reference model starting from reset state
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
    mdl_hi = 32'h0;
    mdl_lo = 32'h0;
    for (int n = 0; n < 80; n++) begin
      gwe = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 7));
      wd  = $urandom;
      rse = 1'($urandom_range(0, 3) != 0);
      rsa = 5'($urandom_range(0, 7));
      rte = 1'($urandom_range(0, 3) != 0);
      rta = 5'($urandom_range(0, 7));
      hwe = 1'($urandom_range(0, 3) == 0);
      hi  = $urandom;
      lo  = $urandom;
      step(0, gwe, wa, wd, rse, rsa, rte, rta, hwe, hi, lo);
      push("rnd_rs", P_RS, mdl_read(rse, rsa, gwe, wa, wd));
      push("rnd_rt", P_RT, mdl_read(rte, rta, gwe, wa, wd));
      push("rnd_hi", P_HI, hwe ? hi : mdl_hi);
      push("rnd_lo", P_LO, hwe ? lo : mdl_lo);
      drain();
      if (gwe && wa != 5'd0) mdl_regs[wa] = wd;
      if (hwe) begin
        mdl_hi = hi;
        mdl_lo = lo;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
